// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS window, byte FIFO and 8N1 serialiser.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    // Address decode
    logic        hit_data_c;
    logic        hit_stat_c;
    logic        push_c;
    logic        clr_ovf_c;
    logic        unused_c;

    assign hit_data_c = (a[31:2] == BASE_ADDR[31:2]);
    assign hit_stat_c = (a[31:2] == (BASE_ADDR[31:2] + 30'd1));
    assign sel        = hit_data_c | hit_stat_c;
    assign push_c     = we & hit_data_c;
    assign clr_ovf_c  = we & hit_stat_c & wd[0];
    assign unused_c   = ^{a[1:0], wd[31:8]};

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;
    logic             full_c;
    logic             empty_c;
    logic             pop_c;
    logic             push_ok_c;
    logic [7:0]       head_c;

    assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_c   = (count_q == '0);
    // A full FIFO still accepts a byte when the serialiser frees a slot on the same edge.
    assign push_ok_c = push_c & (~full_c | pop_c);
    assign head_c    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !push_ok_c) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf_c) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= wd[7:0];
        end
    end

    // Transmit FSM
    state_e            state_q;
    state_e            state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              tx_q;
    logic              tx_d;
    logic              busy_q;
    logic              busy_d;
    logic              baud_last_c;
`ifdef UART_PARITY_EN
    logic              par_q;
    logic              par_d;
`endif

    assign baud_last_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_c   = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = head_c;
`ifdef UART_PARITY_EN
                    par_d   = ^head_c;
`endif
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more bytes are queued.
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = head_c;
`ifdef UART_PARITY_EN
                        par_d   = ^head_c;
`endif
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

    // Read mux: only STATUS returns data
    always_comb begin
        rd = '0;
        if (hit_stat_c) begin
            rd[0]    = busy_q;
            rd[1]    = empty_c;
            rd[2]    = full_c;
            rd[3]    = ovf_q;
            rd[12:8] = 5'(count_q);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic against a frame-level model.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [31:0] a     = 32'h104;
    logic [31:0] wd    = 32'h0;
    logic [31:0] rd;
    logic        sel;
    logic        tx;
    logic        busy;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (32'h0000_0100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .a    (a),
        .wd   (wd),
        .rd   (rd),
        .sel  (sel),
        .tx   (tx),
        .busy (busy)
    );

    // Frame-level model: byte queue plus position inside the current frame
    logic [7:0] m_q[$];
    bit         m_active;
    int         m_t;
    logic [7:0] m_cur;
    logic       m_ovf;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic line_bit(input int t, input logic [7:0] b);
        int k;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        cnt   = 5'(m_q.size());
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        return {19'b0, cnt, 4'b0, m_ovf, full, empty, logic'(m_active)};
    endfunction

    function automatic logic m_sel(input logic [31:0] addr);
        return (addr[31:2] == 30'h40) || (addr[31:2] == 30'h41);
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] addr);
        return (addr[31:2] == 30'h41) ? m_status() : 32'h0;
    endfunction

    task automatic model_edge();
        int         old_size;
        bit         do_pop;
        bit         push_req;
        old_size = m_q.size();
        push_req = we && (a[31:2] == 30'h40);
        if (reset) begin
            m_q.delete();
            m_active = 0;
            m_t      = 0;
            m_ovf    = 1'b0;
            return;
        end
        do_pop = (old_size > 0) && (!m_active || m_t == FRAME - 1);
        if (do_pop) begin
            m_cur    = m_q.pop_front();
            m_active = 1;
            m_t      = 0;
        end else if (m_active) begin
            if (m_t == FRAME - 1) m_active = 0;
            else m_t++;
        end
        if (push_req) begin
            if (old_size < DEPTH || do_pop) m_q.push_back(wd[7:0]);
            else m_ovf = 1'b1;
        end
        if (we && (a[31:2] == 30'h41) && wd[0]) m_ovf = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("tx", 32'(tx), 32'(m_active ? line_bit(m_t, m_cur) : 1'b1));
        chk("busy", 32'(busy), 32'(m_active));
        chk("sel", 32'(sel), 32'(m_sel(a)));
        chk("rd", rd, m_rd(a));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        tick();
        we = 1'b0;
        a  = 32'h104;
        wd = 32'h0;
    endtask

    logic [31:0] addrs [8];
    int          busy_cnt;

    initial begin
        addrs = '{32'h100, 32'h101, 32'h103, 32'h104, 32'h106, 32'h0FC, 32'h108, 32'h200};
        m_active = 0;
        m_t      = 0;
        m_cur    = 8'h0;
        m_ovf    = 1'b0;

        // Reset state and decode boundaries
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_status", rd, 32'h0000_0002);
        a = 32'h100; #1;
        chk("sel_100", 32'(sel), 32'h1);
        chk("rd_data", rd, 32'h0);
        a = 32'h104; #1;
        chk("sel_104", 32'(sel), 32'h1);
        a = 32'h0FC; #1;
        chk("sel_0fc", 32'(sel), 32'h0);
        a = 32'h108; #1;
        chk("sel_108", 32'(sel), 32'h0);
        a = 32'h104;
        idle(2);

        // Single frame: busy spans exactly one frame
        store(32'h100, 32'h55);
        busy_cnt = 0;
        for (int i = 0; i < FRAME + 5; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("busy_len", 32'(busy_cnt), 32'(FRAME));

        // Back-to-back frames
        store(32'h100, 32'h41);
        #1;
        chk("count_after_first", 32'(rd[12:8]), 32'h1);
        store(32'h100, 32'h42);
        busy_cnt = 0;
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("b2b_busy_len", 32'(busy_cnt), 32'(2 * FRAME - 1));

        // Overflow: six consecutive stores, sixth dropped
        for (int i = 0; i < 6; i++) store(32'h100, 32'(8'h30 + i));
        #1;
        chk("ovf_set", 32'(rd[3]), 32'h1);
        chk("full_set", 32'(rd[2]), 32'h1);
        store(32'h104, 32'h1);
        #1;
        chk("ovf_clr", 32'(rd[3]), 32'h0);
        idle(5 * FRAME + 10);

        // Reset in the middle of the data bits
        store(32'h100, 32'hA5);
        idle(CPB + 4 * CPB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_tx", 32'(tx), 32'h1);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_status", rd, 32'h0000_0002);
        idle(FRAME + 10);

`ifdef UART_PARITY_EN
        store(32'h100, 32'h07);
        busy_cnt = 0;
        for (int i = 0; i < FRAME + 5; i++) begin
            tick();
            if (i == 9 * CPB) chk("parity_bit", 32'(tx), 32'h1);
            if (busy) busy_cnt++;
        end
        chk("parity_len", 32'(busy_cnt), 32'd44);
`endif

        // Random bus traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else if (r < 250) begin
                store(addrs[$urandom_range(0, 7)], $urandom);
            end else begin
                a = addrs[$urandom_range(0, 7)];
                tick();
            end
        end
        a = 32'h104;
        idle(DEPTH * FRAME + FRAME + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
